// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end fetch control. Owns the program counter,
// arbitrates fixed-priority redirects, issues one instruction-memory request
// at a time and hands {pc, instr} to decode over a valid/ready handshake.
// Responses belonging to a fetch that a redirect overtook are dropped.
module fetch_sequencer #(
    parameter int PC_WIDTH   = 32,
    parameter int INC_AMOUNT = 4,
    parameter int NUM_REDIR  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PC_WIDTH-1:0]           reset_vector,
    input  logic [NUM_REDIR-1:0]          redir_valid,
    input  logic [NUM_REDIR*PC_WIDTH-1:0] redir_pc,
    output logic [NUM_REDIR-1:0]          redir_grant,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [PC_WIDTH-1:0]           imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [31:0]                   imem_rsp_data,
    output logic                          fetch_valid,
    input  logic                          fetch_ready,
    output logic [PC_WIDTH-1:0]           fetch_pc,
    output logic [31:0]                   fetch_instr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  drop_q, drop_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]           fetch_instr_q, fetch_instr_d;

    logic [NUM_REDIR-1:0]  grant_raw;
    logic [PC_WIDTH-1:0]   redir_target;
    logic                  redir_take;
    logic                  pc_load;
    logic                  pc_inc;

    // Fixed-priority pick: scanning downward lets the lowest set index win.
    always_comb begin
        grant_raw    = '0;
        redir_target = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                grant_raw    = '0;
                grant_raw[i] = 1'b1;
                redir_target = redir_pc[i*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    // Next-state, PC control and output decode; redirects only count outside IDLE.
    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_instr_d = fetch_instr_q;
        pc_inc        = 1'b0;
        redir_take    = (state_q != ST_IDLE) && (|redir_valid);
        pc_load       = redir_take;

        redir_grant    = redir_take ? grant_raw : '0;
        imem_req_valid = (state_q == ST_REQ);
        fetch_valid    = (state_q == ST_HOLD);

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_req_ready) begin
                    // A redirect racing the accepted request orphans its response.
                    state_d = ST_WAIT;
                    drop_d  = redir_take;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                    drop_d  = 1'b0;
                    if (!drop_q && !redir_take) begin
                        fetch_pc_d    = pc_q;
                        fetch_instr_d = imem_rsp_data;
                        pc_inc        = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end else if (redir_take) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                // Without fetch_ready a redirect kills the held instruction.
                if (fetch_ready || redir_take) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pc_load) begin
            pc_d = redir_target;
        end else if (pc_inc) begin
            pc_d = pc_q + PC_WIDTH'(INC_AMOUNT);
        end else begin
            pc_d = pc_q;
        end
    end

    // State, PC and presentation registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= reset_vector;
            drop_q        <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_instr_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_instr_q <= fetch_instr_d;
        end
    end

    assign imem_req_addr = pc_q;
    assign fetch_pc      = fetch_pc_q;
    assign fetch_instr   = fetch_instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of plain fetches plus
// hand-written redirect, kill and reset sequences.
module tb_fetch_sequencer;

    localparam int PW = 32;
    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [PW-1:0]   reset_vector;
    logic [NR-1:0]   redir_valid;
    logic [NR*PW-1:0] redir_pc;
    logic [NR-1:0]   redir_grant;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [PW-1:0]   imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [PW-1:0]   fetch_pc;
    logic [31:0]     fetch_instr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          ready_delay;
        int          rsp_delay;
        int          hold_cycles;
        logic [31:0] instr;
        logic [31:0] exp_pc;
    } vec_t;

    fetch_sequencer #(.PC_WIDTH(PW), .INC_AMOUNT(4), .NUM_REDIR(NR)) dut (
        .clk(clk), .rst_n(rst_n), .reset_vector(reset_vector),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_grant(redir_grant),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic redirect(input logic [NR-1:0] v, input logic [31:0] p0,
                            input logic [31:0] p1, input logic [31:0] p2);
        redir_valid = v;
        redir_pc    = {p2, p1, p0};
    endtask

    // One full fetch starting in REQ, ending back in REQ after decode takes it.
    task automatic do_fetch(input vec_t v);
        for (int d = 0; d < v.ready_delay; d++) begin
            check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("stall_req_addr", imem_req_addr, v.exp_pc);
            tick();
        end
        check("req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("req_addr", imem_req_addr, v.exp_pc);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
        for (int d = 1; d < v.rsp_delay; d++) begin
            tick();
            check("wait_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = v.instr;
        tick();
        imem_rsp_valid = 1'b0;
        for (int h = 0; h < v.hold_cycles; h++) begin
            check("hold_fetch_valid", {31'd0, fetch_valid}, 32'd1);
            tick();
        end
        check("fetch_valid", {31'd0, fetch_valid}, 32'd1);
        check("fetch_pc", fetch_pc, v.exp_pc);
        check("fetch_instr", fetch_instr, v.instr);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        check("post_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("post_req_valid", {31'd0, imem_req_valid}, 32'd1);
    endtask

    vec_t seq[3];

    initial begin
        seq[0] = '{3, 1, 0, 32'h1111_1111, 32'h8000_0000};
        seq[1] = '{0, 1, 0, 32'h2222_2222, 32'h8000_0004};
        seq[2] = '{0, 3, 2, 32'h3333_3333, 32'h8000_0008};

        rst_n = 1'b0; reset_vector = 32'h8000_0000;
        redir_valid = '0; redir_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        fetch_ready = 1'b0;
        tick(); tick();

        // Reset state
        redirect(3'b001, 32'h999, 32'h0, 32'h0);
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_grant", {29'd0, redir_grant}, 32'd0);
        check("rst_fetch_pc", fetch_pc, 32'd0);
        check("rst_fetch_instr", fetch_instr, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_grant", {29'd0, redir_grant}, 32'd0);
        tick();
        redirect(3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        check("idle_redir_ignored", imem_req_addr, 32'h8000_0000);

        // Sequential fetches, including a stalled request
        for (int i = 0; i < 3; i++) do_fetch(seq[i]);

        // Redirect while waiting: response discarded
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        redirect(3'b010, 32'h0, 32'h100, 32'h0);
        #1;
        check("wait_grant", {29'd0, redir_grant}, 32'b010);
        tick();
        redirect(3'b000, 32'h0, 32'h0, 32'h0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        check("drop_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("drop_next_addr", imem_req_addr, 32'h100);
        do_fetch('{0, 1, 0, 32'h4444_4444, 32'h100});

        // Priority and redirect in unaccepted REQ
        redirect(3'b101, 32'h200, 32'h0, 32'h300);
        #1;
        check("prio_grant", {29'd0, redir_grant}, 32'b001);
        tick();
        redirect(3'b000, 32'h0, 32'h0, 32'h0);
        do_fetch('{0, 1, 0, 32'h5555_5555, 32'h200});

        // Redirect coincident with accepted request
        redirect(3'b100, 32'h0, 32'h0, 32'h300);
        imem_req_ready = 1'b1;
        #1;
        check("acc_grant", {29'd0, redir_grant}, 32'b100);
        tick();
        imem_req_ready = 1'b0;
        redirect(3'b000, 32'h0, 32'h0, 32'h0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
        tick();
        imem_rsp_valid = 1'b0;
        check("acc_drop_valid", {31'd0, fetch_valid}, 32'd0);
        check("acc_next_addr", imem_req_addr, 32'h300);
        do_fetch('{0, 1, 0, 32'h6666_6666, 32'h300});

        // HOLD stalled, then killed by redirect
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h7777_7777; tick(); imem_rsp_valid = 1'b0;
        check("kill_hold_pc", fetch_pc, 32'h304);
        for (int i = 0; i < 4; i++) begin
            check("kill_hold_valid", {31'd0, fetch_valid}, 32'd1);
            tick();
        end
        redirect(3'b001, 32'h400, 32'h0, 32'h0);
        tick();
        redirect(3'b000, 32'h0, 32'h0, 32'h0);
        check("kill_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("kill_next_addr", imem_req_addr, 32'h400);
        do_fetch('{0, 1, 0, 32'h8888_8888, 32'h400});

        // HOLD with decode handshake and redirect together
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h9999_9999; tick(); imem_rsp_valid = 1'b0;
        check("hs_fetch_pc", fetch_pc, 32'h404);
        fetch_ready = 1'b1;
        redirect(3'b010, 32'h0, 32'h500, 32'h0);
        tick();
        fetch_ready = 1'b0;
        redirect(3'b000, 32'h0, 32'h0, 32'h0);
        check("hs_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("hs_next_addr", imem_req_addr, 32'h500);

        // Reset during WAIT, stray response in IDLE, then PC wrap
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        rst_n = 1'b0; reset_vector = 32'hFFFF_FFFC;
        tick();
        rst_n = 1'b1;
        check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("mid_rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("mid_rst_fetch_pc", fetch_pc, 32'd0);
        check("mid_rst_fetch_instr", fetch_instr, 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_CAFE;
        tick();
        imem_rsp_valid = 1'b0;
        check("stray_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        do_fetch('{0, 1, 0, 32'hAAAA_AAAA, 32'hFFFF_FFFC});
        do_fetch('{0, 2, 1, 32'hBBBB_BBBB, 32'h0000_0000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
